// File: rtl/serial_hex_seq.sv
// Sequences a Wishbone byte-serial transmitter: prints a latched value as
// uppercase ASCII hex (MSB nibble first), optionally followed by CR LF.
module serial_hex_seq #(
  parameter int NDIGITS = 2,
  parameter int CRLF    = 1
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   value,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             wb_dat_o,
  output logic                   wb_we_o,
  output logic                   wb_stb_o,
  output logic                   wb_cyc_o,
  input  logic                   wb_ack_i,
  output logic [1:0]             dbg_state_o
);

  localparam int TOTAL = NDIGITS + 2 * CRLF;
  localparam int CW    = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state_q;
  logic [4*NDIGITS-1:0] val_q;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 stb_q;
  logic [7:0]           dat_q;

  // Character at position idx of the dump: hex digits first, then CR, LF.
  function automatic logic [7:0] char_of(input logic [4*NDIGITS-1:0] v,
                                         input logic [CW-1:0] idx);
    logic [3:0] nib;
    logic [7:0] c;
    int         sh;
    nib = 4'h0;
    c   = 8'h00;
    sh  = 0;
    if (int'(idx) < NDIGITS) begin
      sh  = 4 * (NDIGITS - 1 - int'(idx));
      nib = 4'(v >> sh);
      c   = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    end else if (int'(idx) == NDIGITS) begin
      c = 8'h0D;
    end else begin
      c = 8'h0A;
    end
    return c;
  endfunction

  // Wishbone handshake: stb/cyc/we rise together with wb_dat_o valid and
  // stay stable until wb_ack_i is sampled high; ack while stb is low is ignored.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      val_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stb_q   <= 1'b0;
      dat_q   <= 8'h00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            val_q   <= value;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            stb_q   <= 1'b1;
            dat_q   <= char_of(value, '0);
            state_q <= SEND;
          end
        end
        SEND: begin
          if (wb_ack_i) begin
            cnt_q   <= cnt_q + CW'(1);
            stb_q   <= 1'b0;
            state_q <= GAP;
          end
        end
        GAP: begin
          // One strobe-low cycle per byte so the transmitter sees a fresh edge.
          if (cnt_q == CW'(TOTAL)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            stb_q   <= 1'b1;
            dat_q   <= char_of(val_q, cnt_q);
            state_q <= SEND;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign wb_dat_o    = dat_q;
  assign wb_stb_o    = stb_q;
  assign wb_cyc_o    = stb_q;
  assign wb_we_o     = stb_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/serial_hex_seq.md
Name: serial_hex_seq

Overview:
- Controller that sequences the Wishbone byte-serial transmitter (`send_serial`). It turns a latched binary value into uppercase ASCII hex digits, MSB nibble first, optionally followed by CR LF.
- Issues one Wishbone write per character and waits for the transmitter's ack before moving to the next.
- Runs in the UART clock domain (`clk_921600` / `rst2` from `clk_uart`). Debug logic uses it to dump registers over the serial line.

Parameters:
- NDIGITS, 2, number of hex digits sent; value width is 4*NDIGITS bits; legal range 1..8.
- CRLF, 1, 1 = append 0x0D then 0x0A after the digits; 0 = digits only.

Ports:
- wb_clk_i  input  1  clock; all state changes on its rising edge.
- wb_rst_i  input  1  reset, synchronous, active-high.
- start     input  1  request a dump; sampled only in IDLE.
- value     input  4*NDIGITS  value to print; latched on the accepted start.
- busy      output 1  high from the cycle after an accepted start until the return to IDLE.
- done      output 1  one-cycle pulse on the first IDLE cycle after the last byte is acked.
- wb_dat_o  output 8  character presented to the transmitter.
- wb_we_o   output 1  write enable; equals wb_stb_o.
- wb_stb_o  output 1  strobe.
- wb_cyc_o  output 1  cycle; equals wb_stb_o.
- wb_ack_i  input  1  transmitter ack; byte accepted/sent.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, wb_stb_o=wb_cyc_o=wb_we_o=0, wb_dat_o=8'h00, char counter=0.
- All outputs are registered.
- TOTAL = NDIGITS + 2*CRLF characters per dump.
- Character index i (0..TOTAL-1):
  - i<NDIGITS: nibble = value_latched[4*(NDIGITS-1-i)+:4].
    - Nibble 0..9 maps to 8'h30+n.
    - Nibble 10..15 maps to 8'h41+(n-10).
  - i=NDIGITS: 8'h0D.
  - i=NDIGITS+1: 8'h0A.
- State IDLE:
  - busy=0, stb=0.
  - If start=1 at edge k: latch value, counter=0, go to SEND.
  - In cycle k+1: busy=1, stb=cyc=we=1, wb_dat_o = char 0.
- State SEND:
  - stb held high and wb_dat_o held stable until wb_ack_i=1 is sampled.
  - On ack: counter++, go to GAP. stb=0 in the next cycle.
- State GAP:
  - Exactly one cycle with stb=0. This guarantees a strobe edge per byte, because the transmitter retransmits while stb stays high.
  - If counter==TOTAL: go to IDLE with done=1 in that first IDLE cycle. busy=0 in the same cycle.
  - Otherwise: go to SEND, wb_dat_o = char(counter).
- Throughput: 2 cycles of overhead per byte beyond the ack latency. An ack on the first SEND cycle gives 2 cycles per byte.
- wb_ack_i while stb=0 (IDLE or GAP) is ignored.
- start while busy is ignored; it is not queued.
- start in the same cycle done=1 is accepted, so back-to-back dumps work.
- value changes after the latch do not affect the dump in progress.
- Reset in any state:
  - Next edge gives reset values: stb drops immediately, no done pulse.
  - The partial dump is abandoned, not resumed.
- Counter width is ceil(log2(TOTAL+1)). No wrap is possible within a dump.

Test Plan:
- Basic dump, NDIGITS=2, CRLF=1, value=8'h4B, slave acks 3 cycles after stb rises.
  - Bytes in order: 0x34, 0x42, 0x0D, 0x0A.
  - stb low exactly 1 cycle between bytes.
  - done pulses once; busy falls with done.
- Digit mapping, NDIGITS=4, CRLF=0, value=16'h09AF.
  - Bytes in order: 0x30, 0x39, 0x41, 0x46. No CR/LF.
  - done after the 4th ack.
- Handshake hold, ack delayed 200 cycles.
  - wb_dat_o and stb stable for all 200 cycles.
  - A spurious ack during GAP/IDLE causes no extra byte and no counter change.
- start while busy and value change mid-dump.
  - Pulse start with value=8'hFF during byte 1: ignored, the dump still sends 0x34 0x42.
  - start coincident with done starts a new dump: stb rises the next cycle.
- Reset mid-operation.
  - Assert wb_rst_i while byte 2 is strobed: stb=0 and busy=0 on the next edge, no done.
  - A new start then sends from char 0.
- Integration with clk_uart + send_serial.
  - Value 8'h4B: the trx_ line decodes as "4B\r\n" at 921600 baud.
